gf2_poly_alu: RTL and testbench

- Polynomial ALU for the Niederreiter cryptoprocessor datapath.
- Operates on binary polynomials over GF(2) of up to 144 coefficients, with an optional degree-144 modulus.
- Operands are loaded by select strobes. The op code picks one of eight operations. Results appear on two 144-bit buses, and `compute_done` pulses when they are valid.
- Sits between the register file / controller and the instruction decoder.

---
 rtl/gf2_alu_pkg.sv | 29 ++
 rtl/gf2_deg_enc.sv | 21 ++
 rtl/gf2_poly_alu.sv | 165 ++++++++++++++++
 tb/tb_gf2_poly_alu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_alu_pkg.sv
// Shared definitions for the GF(2) polynomial ALU: widths, op codes, FSM states and the
// multiply-by-x-with-reduction step used by SHIFT and MULT.
package gf2_alu_pkg;

  localparam int unsigned DAT_W  = 144;
  localparam int unsigned LDAT_W = 145;
  localparam int unsigned CNT_W  = 8;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SPLIT = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0101;
  localparam logic [3:0] OP_INV   = 4'b0110;
  localparam logic [3:0] OP_DEG   = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_EVAL  = 4'b1001;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DAT_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Polynomials here are little-endian: bit k holds the x^k coefficient.
  // m is the modulus without its implicit x^144 term.
  function automatic logic [DAT_W-1:0] mul_x_mod(input logic [DAT_W-1:0] p,
                                                 input logic [DAT_W-1:0] m);
    return {p[DAT_W-2:0], 1'b0} ^ (p[DAT_W-1] ? m : '0);
  endfunction

endpackage

// File: rtl/gf2_deg_enc.sv
// Degree of a 144-coefficient polynomial (index of highest set bit) plus an all-zero flag.
module gf2_deg_enc
  import gf2_alu_pkg::*;
(
  input  logic [DAT_W-1:0] poly,
  output logic [CNT_W-1:0] deg,
  output logic             zero
);

  always_comb begin
    deg  = '0;
    zero = 1'b1;
    for (int i = 0; i < DAT_W; i++) begin
      if (poly[i]) begin
        deg  = CNT_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gf2_poly_alu.sv
// GF(2) polynomial ALU: single-cycle bitwise ops plus 144-iteration serial MULT and DIV.
// Buses are MSB-first (index 0 = highest coefficient); internally everything is little-endian.
module gf2_poly_alu
  import gf2_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic [3:0]        alu_typ_sel,
  input  logic              alu_o_sel,
  input  logic              alu_t_sel,
  input  logic              alu_mod_sel,
  input  logic [0:LDAT_W-1] alu_o_dat,
  input  logic [0:DAT_W-1]  alu_t_dat,
  input  logic [0:LDAT_W-1] alu_mod_dat,
  output logic [0:DAT_W-1]  alu_r_dat1,
  output logic [0:DAT_W-1]  alu_r_dat2,
  output logic              compute_done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dd_q, dd_d, iter, enc_deg;
  logic [CNT_W:0]   tgt;
  logic [3:0]       op_q, op_d;
  logic [DAT_W-1:0] o_q, t_q, m_q;
  logic [DAT_W-1:0] acc_q, acc_d, quo_q, quo_d, r1_q, r1_d, r2_q, r2_d;
  logic [DAT_W-1:0] a_bus, b_bus, m_bus, enc_in, mul_acc, sc_r1, sc_r2;
  logic             o_sel_q, start, enc_zero, unused_lead;

  // Plain range assignment maps bus index 0 onto the little-endian MSB.
  assign a_bus = alu_o_dat[1:LDAT_W-1];
  assign b_bus = alu_t_dat;
  assign m_bus = alu_mod_dat[1:LDAT_W-1];
  // The x^144 slots of o and M never take part in any result.
  assign unused_lead = alu_o_dat[0] ^ alu_mod_dat[0];

  assign start = alu_o_sel & ~o_sel_q;

  // DEG needs deg(A) and DIV needs deg(B); both only at start, so one encoder serves both.
  assign enc_in = (alu_typ_sel == OP_DIV) ? b_bus : a_bus;

  gf2_deg_enc u_deg_enc (
    .poly (enc_in),
    .deg  (enc_deg),
    .zero (enc_zero)
  );

  always_comb begin
    sc_r1 = '0;
    sc_r2 = '0;
    case (alu_typ_sel)
      OP_ADD:   sc_r1 = a_bus ^ b_bus;
      OP_SPLIT: begin
        for (int j = 0; j < DAT_W / 2; j++) begin
          sc_r1[j] = a_bus[2*j];
          sc_r2[j] = a_bus[2*j+1];
        end
      end
      OP_INV: begin
        for (int j = 0; j < DAT_W; j++) sc_r1[j] = a_bus[DAT_W-1-j];
      end
      OP_DEG: begin
        sc_r1[CNT_W-1:0] = enc_deg;
        sc_r2[0]         = enc_zero;
      end
      OP_SHIFT: begin
        sc_r1 = mul_x_mod(a_bus, m_bus);
        sc_r2 = mul_x_mod(b_bus, m_bus);
      end
      OP_EVAL:  sc_r1[0] = ^(a_bus & b_bus);
      OP_DIV:   sc_r2 = a_bus;  // only reached with B == 0
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dd_d    = dd_q;
    op_d    = op_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    r1_d    = r1_q;
    r2_d    = r2_q;

    // Iterations run from the top coefficient down.
    iter    = LAST_ITER - cnt_q;
    tgt     = {1'b0, iter} + {1'b0, dd_q};
    mul_acc = mul_x_mod(acc_q, m_q) ^ (o_q[iter] ? t_q : '0);

    unique case (state_q)
      StIdle: ;
      StRun: begin
        if (op_q == OP_MULT) begin
          acc_d = mul_acc;
        end else if (tgt <= {1'b0, LAST_ITER} && acc_q[tgt[CNT_W-1:0]]) begin
          acc_d       = acc_q ^ (t_q << iter);
          quo_d[iter] = 1'b1;
        end
        if (cnt_q == LAST_ITER) begin
          state_d = StDone;
          r1_d    = (op_q == OP_MULT) ? acc_d : quo_d;
          r2_d    = (op_q == OP_MULT) ? '0 : acc_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A start edge wins in every state, which is also how a busy operation gets aborted.
    if (start) begin
      op_d  = alu_typ_sel;
      cnt_d = '0;
      dd_d  = enc_deg;
      quo_d = '0;
      if (alu_typ_sel == OP_MULT) begin
        state_d = StRun;
        acc_d   = '0;
      end else if (alu_typ_sel == OP_DIV && !enc_zero) begin
        state_d = StRun;
        acc_d   = a_bus;
      end else begin
        state_d = StDone;
        r1_d    = sc_r1;
        r2_d    = sc_r2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dd_q    <= '0;
      op_q    <= '0;
      o_q     <= '0;
      t_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      o_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dd_q    <= dd_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      o_sel_q <= alu_o_sel;
      if (alu_o_sel) o_q <= a_bus;
      if (alu_t_sel || start) t_q <= b_bus;
      if (alu_mod_sel || start) m_q <= m_bus;
    end
  end

  assign alu_r_dat1   = r1_q;
  assign alu_r_dat2   = r2_q;
  assign compute_done = (state_q == StDone);

endmodule

// File: tb/tb_gf2_poly_alu.sv
// Scoreboard bench for gf2_poly_alu: random and directed ops checked against an algebraic
// reference model (full products, true long division), including result latency.
module tb_gf2_poly_alu;

  logic         clk = 1'b0;
  logic         rst_b;
  logic [3:0]   alu_typ_sel;
  logic         alu_o_sel, alu_t_sel, alu_mod_sel;
  logic [0:144] alu_o_dat;
  logic [0:143] alu_t_dat;
  logic [0:144] alu_mod_dat;
  logic [0:143] alu_r_dat1, alu_r_dat2;
  logic         compute_done;

  always #5 clk = ~clk;

  gf2_poly_alu dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .alu_typ_sel  (alu_typ_sel),
    .alu_o_sel    (alu_o_sel),
    .alu_t_sel    (alu_t_sel),
    .alu_mod_sel  (alu_mod_sel),
    .alu_o_dat    (alu_o_dat),
    .alu_t_dat    (alu_t_dat),
    .alu_mod_dat  (alu_mod_dat),
    .alu_r_dat1   (alu_r_dat1),
    .alu_r_dat2   (alu_r_dat2),
    .compute_done (compute_done)
  );

  typedef struct packed {
    logic [143:0] r1;
    logic [143:0] r2;
    logic [31:0]  due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // ---------------- reference model (little-endian: bit k = x^k) ----------------
  function automatic int pdeg(input logic [143:0] p);
    for (int i = 143; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  // Full 287-bit product, then reduction modulo x^144 + ml.
  function automatic logic [143:0] mulmod(input logic [143:0] a, input logic [143:0] b,
                                          input logic [143:0] ml);
    logic [287:0] p;
    p = '0;
    for (int i = 0; i < 144; i++) if (a[i]) p ^= {144'b0, b} << i;
    for (int k = 287; k >= 144; k--) if (p[k]) p ^= {143'b0, 1'b1, ml} << (k - 144);
    return p[143:0];
  endfunction

  task automatic pdiv(input logic [143:0] a, input logic [143:0] b,
                      output logic [143:0] q, output logic [143:0] r);
    int db, dr;
    q  = '0;
    r  = a;
    db = pdeg(b);
    dr = pdeg(r);
    while (dr >= db) begin
      q[dr-db] = 1'b1;
      r ^= b << (dr - db);
      dr = pdeg(r);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [143:0] a, input logic [143:0] b,
                       input logic [143:0] ml, output logic [143:0] r1,
                       output logic [143:0] r2, output int lat);
    int d;
    r1  = '0;
    r2  = '0;
    lat = 1;
    case (op)
      4'd1: r1 = a ^ b;
      4'd2: for (int j = 0; j < 72; j++) begin r1[j] = a[2*j]; r2[j] = a[2*j+1]; end
      4'd3: begin r1 = mulmod(a, b, ml); lat = 145; end
      4'd5: if (b == '0) r2 = a; else begin pdiv(a, b, r1, r2); lat = 145; end
      4'd6: for (int j = 0; j < 144; j++) r1[143-j] = a[j];
      4'd7: begin
        d = pdeg(a);
        if (d < 0) r2[0] = 1'b1;
        else r1[7:0] = 8'(d);
      end
      4'd8: begin r1 = mulmod(a, 144'd2, ml); r2 = mulmod(b, 144'd2, ml); end
      4'd9: r1[0] = ^(a & b);
      default: ;
    endcase
  endtask

  function automatic logic [143:0] rnd();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[143:0];
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic [143:0] a, input logic [143:0] b,
                       input logic [143:0] ml, input int hold, input bit abort_prev);
    exp_t e;
    int   lat;
    @(negedge clk);
    alu_t_dat   = b;
    alu_mod_dat = {1'($urandom), ml};
    alu_t_sel   = 1'b1;
    alu_mod_sel = 1'b1;
    @(negedge clk);
    alu_t_sel   = 1'b0;
    alu_mod_sel = 1'b0;
    alu_typ_sel = op;
    alu_o_dat   = {1'($urandom), a};
    alu_o_sel   = 1'b1;
    if (abort_prev && exp_q.size() > 0) void'(exp_q.pop_back());
    model(op, a, b, ml, e.r1, e.r2, lat);
    e.due = 32'(cyc + lat);
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    alu_o_sel = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (compute_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("r_dat1", alu_r_dat1, mon_e.r1);
        chk("r_dat2", alu_r_dat2, mon_e.r2);
        chk("latency_cycle", 144'(cyc), 144'(mon_e.due));
      end
    end
  end

  initial begin
    logic [143:0] a, b, ml, mask;
    logic [3:0]   op;
    int           d;

    rst_b       = 1'b0;
    alu_typ_sel = '0;
    alu_o_sel   = 1'b0;
    alu_t_sel   = 1'b0;
    alu_mod_sel = 1'b0;
    alu_o_dat   = '0;
    alu_t_dat   = '0;
    alu_mod_dat = '0;
    repeat (5) @(negedge clk);
    chk("reset_r1", alu_r_dat1, '0);
    chk("reset_r2", alu_r_dat2, '0);
    chk("reset_done", 144'(compute_done), '0);
    rst_b = 1'b1;

    ml = rnd();
    issue(4'b0001, 144'hfff1, 144'h0f0f, ml, 1, 0);  drain();
    issue(4'b0111, '0, rnd(), ml, 1, 0);              drain();
    issue(4'b0111, 144'b1 << 100, rnd(), ml, 1, 0);   drain();
    issue(4'b0010, 144'b1011, rnd(), ml, 1, 0);       drain();
    issue(4'b0110, 144'b1, rnd(), ml, 1, 0);          drain();
    issue(4'b1000, 144'b1 << 143, rnd(), ml, 1, 0);   drain();
    issue(4'b1001, rnd(), rnd(), ml, 1, 0);           drain();
    issue(4'b0000, rnd(), rnd(), ml, 1, 0);           drain();
    issue(4'b1111, rnd(), rnd(), ml, 1, 0);           drain();
    issue(4'b0011, 144'b1, rnd(), ml, 1, 0);          drain();
    issue(4'b0101, 144'b1001, 144'b11, ml, 2, 0);     drain();
    issue(4'b0101, rnd(), '0, ml, 1, 0);              drain();

    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = rnd();
      b  = rnd();
      if (op == 4'b0101) begin
        d    = $urandom_range(0, 143);
        mask = '1;
        b    = (b & (mask >> (143 - d))) | (144'b1 << d);
        if ($urandom_range(0, 7) == 0) b = '0;
      end
      issue(op, a, b, rnd(), 1, 0);
      drain();
    end

    // New start while MULT is running replaces it.
    issue(4'b0011, rnd(), rnd(), rnd(), 1, 0);
    repeat (50) @(negedge clk);
    issue(4'b0001, rnd(), rnd(), rnd(), 1, 1);
    drain();

    // Reset in the middle of a DIV.
    issue(4'b0101, rnd(), 144'h1_2345, rnd(), 1, 0);
    repeat (30) @(negedge clk);
    rst_b = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_r1", alu_r_dat1, '0);
    chk("midreset_r2", alu_r_dat2, '0);
    chk("midreset_done", 144'(compute_done), '0);
    rst_b = 1'b1;
    repeat (200) @(negedge clk);
    chk("postreset_r1", alu_r_dat1, '0);
    chk("postreset_r2", alu_r_dat2, '0);
    issue(4'b0001, rnd(), rnd(), rnd(), 1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
